// File: rtl/aes_vec_sequencer.sv
// Steps through a table of {key, state, expected} vectors and holds each one on an AES core
// for a fixed time. It captures the core result at the end of each hold and keeps a count of mismatches.
module aes_vec_sequencer #(
  parameter  int NUM_VEC     = 4,
  parameter  int HOLD_CYCLES = 32,
  parameter  int DW          = 128,
  parameter  int LOOP        = 0,
  localparam int AW          = $clog2(NUM_VEC)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_key,
  input  logic [DW-1:0] wr_state,
  input  logic [DW-1:0] wr_exp,
  input  logic          start,
  input  logic          abort,
  output logic [DW-1:0] key_o,
  output logic [DW-1:0] state_o,
  input  logic [DW-1:0] dut_out_i,
  output logic          cap_valid,
  output logic [AW-1:0] cap_idx,
  output logic [DW-1:0] cap_data,
  output logic          cap_mismatch,
  output logic          busy,
  output logic          done,
  output logic [7:0]    err_cnt
);

  localparam int HW = $clog2(HOLD_CYCLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_next;
  logic [HW-1:0] hold, hold_next;
  logic [AW-1:0] slot, slot_next;
  logic          go, sample, hold_last, last_slot, mismatch, wr_ok;

  logic [DW-1:0] key_mem   [NUM_VEC];
  logic [DW-1:0] state_mem [NUM_VEC];
  logic [DW-1:0] exp_mem   [NUM_VEC];

  assign hold_last = (hold == HW'(HOLD_CYCLES - 1));
  assign last_slot = (slot == AW'(NUM_VEC - 1));
  assign mismatch  = (dut_out_i != exp_mem[slot]);
  assign wr_ok     = wr_en && (state != RUN) && (32'(wr_addr) < 32'(NUM_VEC));
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next = state;
    hold_next  = hold;
    slot_next  = slot;
    go         = 1'b0;
    sample     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = RUN;
          go         = 1'b1;
          hold_next  = '0;
          slot_next  = '0;
        end
      end
      RUN: begin
        if (hold_last) begin
          sample    = 1'b1;
          hold_next = '0;
          if (!last_slot) begin
            slot_next = slot + 1'b1;
          end else begin
            slot_next = '0;
            if (LOOP == 0) state_next = DONE;
          end
        end else begin
          hold_next = hold + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // Abort overrides start, the hold wrap and the capture that the wrap would have produced.
    if (abort) begin
      state_next = IDLE;
      go         = 1'b0;
      sample     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold         <= '0;
      slot         <= '0;
      key_o        <= '0;
      state_o      <= '0;
      cap_valid    <= 1'b0;
      cap_idx      <= '0;
      cap_data     <= '0;
      cap_mismatch <= 1'b0;
      err_cnt      <= '0;
    end else begin
      hold <= hold_next;
      slot <= slot_next;
      // Look up the next slot so that the vector is already registered on the first cycle of its hold.
      if (state_next == RUN) begin
        key_o   <= key_mem[slot_next];
        state_o <= state_mem[slot_next];
      end else begin
        key_o   <= '0;
        state_o <= '0;
      end
      cap_valid <= sample;
      if (sample) begin
        cap_idx      <= slot;
        cap_data     <= dut_out_i;
        cap_mismatch <= mismatch;
      end
      if (go)                                       err_cnt <= '0;
      else if (sample && mismatch && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  // NOTE: the vector table has no reset on purpose, so a reset leaves the loaded vectors in place.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      key_mem[wr_addr]   <= wr_key;
      state_mem[wr_addr] <= wr_state;
      exp_mem[wr_addr]   <= wr_exp;
    end
  end

endmodule

// File: tb/tb_aes_vec_sequencer.sv
// Randomised bench for aes_vec_sequencer. One instance uses the defaults and a second loops (NUM_VEC=2, HOLD_CYCLES=4).
// A stand-in cipher feeds the result input, and expectations come from cycle arithmetic over a table model.
module tb_aes_vec_sequencer;

  localparam int NV = 4;
  localparam int H  = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en, start, abort;
  logic [1:0]   wr_addr;
  logic [127:0] wr_key, wr_state, wr_exp;
  logic [127:0] key_o, state_o, dut_out, cap_data;
  logic         cap_valid, cap_mismatch, busy, done;
  logic [1:0]   cap_idx;
  logic [7:0]   err_cnt;

  logic         l_wr_en, l_start, l_abort;
  logic [0:0]   l_wr_addr;
  logic [127:0] l_wr_key, l_wr_state, l_wr_exp;
  logic [127:0] l_key_o, l_state_o, l_dut_out, l_cap_data;
  logic         l_cap_valid, l_cap_mismatch, l_busy, l_done;
  logic [0:0]   l_cap_idx;
  logic [7:0]   l_err_cnt;

  logic [127:0] tk [NV];
  logic [127:0] ts [NV];
  logic [127:0] te [NV];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Stand-in for the AES core: any fixed function of key and state will do for sequencing checks.
  function automatic logic [127:0] cipher(input logic [127:0] k, input logic [127:0] s);
    return (k ^ {s[63:0], s[127:64]}) + 128'h1;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  assign dut_out   = cipher(key_o, state_o);
  assign l_dut_out = cipher(l_key_o, l_state_o);

  aes_vec_sequencer u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_key(wr_key),
    .wr_state(wr_state), .wr_exp(wr_exp), .start(start), .abort(abort),
    .key_o(key_o), .state_o(state_o), .dut_out_i(dut_out), .cap_valid(cap_valid),
    .cap_idx(cap_idx), .cap_data(cap_data), .cap_mismatch(cap_mismatch),
    .busy(busy), .done(done), .err_cnt(err_cnt)
  );

  aes_vec_sequencer #(.NUM_VEC(2), .HOLD_CYCLES(4), .LOOP(1)) u_loop (
    .clk(clk), .rst(rst), .wr_en(l_wr_en), .wr_addr(l_wr_addr), .wr_key(l_wr_key),
    .wr_state(l_wr_state), .wr_exp(l_wr_exp), .start(l_start), .abort(l_abort),
    .key_o(l_key_o), .state_o(l_state_o), .dut_out_i(l_dut_out), .cap_valid(l_cap_valid),
    .cap_idx(l_cap_idx), .cap_data(l_cap_data), .cap_mismatch(l_cap_mismatch),
    .busy(l_busy), .done(l_done), .err_cnt(l_err_cnt)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  task automatic load_slot(input int a, input logic [127:0] k, input logic [127:0] s,
                           input logic [127:0] e);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a[1:0]; wr_key = k; wr_state = s; wr_exp = e;
    @(negedge clk);
    wr_en = 1'b0;
    tk[a] = k; ts[a] = s; te[a] = e;
  endtask

  // Start a run and check every cycle. The abort, write-plus-start injection or reset pulse
  // happens during the cycle number given; a negative cycle number disables that event.
  task automatic run_check(input int ncyc, input int abort_at, input int inject_at, input int rst_at);
    int  exp_err, k, idx;
    bit  alive, run_m, cap_m, mis;
    @(negedge clk);
    start = 1'b1;
    exp_err = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; wr_en = 1'b0;
      alive = (abort_at < 0 || c <= abort_at) && (rst_at < 0 || c <= rst_at);
      k     = (c - 1) / H;
      run_m = alive && (c - 1) < NV * H;
      cap_m = alive && c > 1 && (c - 1) % H == 0 && k >= 1 && k <= NV;
      check($sformatf("busy c%0d", c), 128'(busy), 128'(run_m));
      check($sformatf("done c%0d", c), 128'(done), 128'(alive && !run_m));
      check($sformatf("key_o c%0d", c), key_o, run_m ? tk[k] : 128'h0);
      check($sformatf("state_o c%0d", c), state_o, run_m ? ts[k] : 128'h0);
      check($sformatf("cap_valid c%0d", c), 128'(cap_valid), 128'(cap_m));
      if (cap_m) begin
        idx = k - 1;
        mis = (te[idx] != cipher(tk[idx], ts[idx]));
        if (mis && exp_err < 255) exp_err++;
        check($sformatf("cap_idx c%0d", c), 128'(cap_idx), 128'(idx));
        check($sformatf("cap_data c%0d", c), cap_data, cipher(tk[idx], ts[idx]));
        check($sformatf("cap_mismatch c%0d", c), 128'(cap_mismatch), 128'(mis));
        check($sformatf("err_cnt c%0d", c), 128'(err_cnt), 128'(exp_err));
      end
      if (!alive) check($sformatf("err_cnt dead c%0d", c), 128'(err_cnt), 128'(exp_err));
      if (c == abort_at) abort = 1'b1;
      if (c == inject_at) begin
        wr_en = 1'b1; wr_addr = 2'd2; wr_key = rnd128(); wr_state = rnd128(); wr_exp = rnd128();
        start = 1'b1;
      end
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst key_o", key_o, 128'h0);
        check("rst state_o", state_o, 128'h0);
        check("rst cap_valid", 128'(cap_valid), 128'h0);
        check("rst cap_data", cap_data, 128'h0);
        check("rst cap_idx", 128'(cap_idx), 128'h0);
        check("rst busy/done", 128'({busy, done}), 128'h0);
        check("rst err_cnt", 128'(err_cnt), 128'h0);
        rst = 1'b0;
        exp_err = 0;
      end
    end
    check("err_cnt end", 128'(err_cnt), 128'(exp_err));
  endtask

  initial begin
    int bad;
    rst = 1'b1; wr_en = 1'b0; start = 1'b0; abort = 1'b0;
    wr_addr = '0; wr_key = '0; wr_state = '0; wr_exp = '0;
    l_wr_en = 1'b0; l_start = 1'b0; l_abort = 1'b0;
    l_wr_addr = '0; l_wr_key = '0; l_wr_state = '0; l_wr_exp = '0;
    repeat (3) @(negedge clk);
    check("reset key_o", key_o, 128'h0);
    check("reset cap_valid", 128'(cap_valid), 128'h0);
    check("reset busy/done", 128'({busy, done}), 128'h0);
    check("reset err_cnt", 128'(err_cnt), 128'h0);
    rst = 1'b0;

    // The looping instance uses two slots held for 4 cycles each and never reaches DONE.
    for (int a = 0; a < 2; a++) begin
      @(negedge clk);
      l_wr_en = 1'b1; l_wr_addr = a[0:0];
      l_wr_key = rnd128(); l_wr_state = rnd128(); l_wr_exp = cipher(l_wr_key, l_wr_state);
      tk[a] = l_wr_key; ts[a] = l_wr_state;
    end
    @(negedge clk);
    l_wr_en = 1'b0; l_start = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      l_start = 1'b0;
      check($sformatf("loop busy c%0d", c), 128'(l_busy), 128'h1);
      check($sformatf("loop done c%0d", c), 128'(l_done), 128'h0);
      check($sformatf("loop key_o c%0d", c), l_key_o, tk[((c - 1) / 4) % 2]);
      check($sformatf("loop cap_valid c%0d", c), 128'(l_cap_valid), 128'(c > 1 && (c - 1) % 4 == 0));
      if (c > 1 && (c - 1) % 4 == 0) begin
        check($sformatf("loop cap_idx c%0d", c), 128'(l_cap_idx), 128'((((c - 1) / 4) - 1) % 2));
        check($sformatf("loop cap_mismatch c%0d", c), 128'(l_cap_mismatch), 128'h0);
      end
    end
    l_abort = 1'b1;
    @(negedge clk);
    l_abort = 1'b0;
    check("loop abort busy", 128'(l_busy), 128'h0);

    // Full runs: first against correct expectations, then with one expectation bit flipped.
    for (int it = 0; it < 2; it++) begin
      for (int a = 0; a < NV; a++) begin
        logic [127:0] k, s;
        if (it == 0 && a == 0) begin
          k = 128'h0000_1111_ffff_0000_2222_ffff_3333_ffff;
          s = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
        end else begin
          k = rnd128(); s = rnd128();
        end
        load_slot(a, k, s, cipher(k, s));
      end
      run_check(NV * H + 3, -1, -1, -1);
      bad = (it == 0) ? 2 : int'($urandom_range(NV - 1));
      load_slot(bad, tk[bad], ts[bad], te[bad] ^ 128'h1);
      run_check(NV * H + 3, -1, -1, -1);
    end

    // Abort at hold 10 of slot 1 keeps err_cnt and drops the slot 1 capture.
    run_check(2 * H + 8, H + 11, -1, -1);

    // start and abort together from IDLE stay idle.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start+abort busy", 128'(busy), 128'h0);
    check("start+abort key_o", key_o, 128'h0);

    // A write and a start during RUN change nothing.
    run_check(NV * H + 3, -1, 20, -1);

    // A reset pulse while the slot 0 capture is showing, then a rerun over the untouched table.
    run_check(40, -1, -1, H + 1);
    run_check(NV * H + 3, -1, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
